// File: rtl/data_bus_interconnect.sv
// data_bus_interconnect: one core data port to N memory-mapped slaves.
// Regions are decoded by base/mask; the lowest-index hit wins. Each region can
// be marked read-only. A registered request drives one active-low chip select
// until the slave signals ready; the core sees a one-cycle ack with an error
// qualifier and a sticky cause/address of the last fault.
// Optional feature: define BUS_TIMEOUT_EN to abort slave accesses that never
// signal ready within TIMEOUT_CYCLES cycles (error cause 2'b11).
module data_bus_interconnect #(
  parameter int unsigned                    N_SLAVES       = 4,
  parameter int unsigned                    DATA_WIDTH     = 32,
  parameter int unsigned                    ADDR_WIDTH     = 32,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE       = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_MASK       = '0,
  parameter logic [N_SLAVES-1:0]            SLV_RO         = '0,
  parameter int unsigned                    TIMEOUT_CYCLES = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           req_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic                           wen_i,
  input  logic [DATA_WIDTH/8-1:0]        wmask_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           ack_o,
  output logic                           err_o,
  output logic [1:0]                     err_cause_o,
  output logic [ADDR_WIDTH-1:0]          err_addr_o,
  output logic [N_SLAVES-1:0]            slv_csb_o,
  output logic                           slv_wen_o,
  output logic [ADDR_WIDTH-1:0]          slv_addr_o,
  output logic [DATA_WIDTH/8-1:0]        slv_wmask_o,
  output logic [DATA_WIDTH-1:0]          slv_wdata_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] slv_rdata_i,
  input  logic [N_SLAVES-1:0]            slv_ready_i
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned SelW  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseUnmapped = 2'b01;
  localparam logic [1:0] CauseRoWrite  = 2'b10;
`ifdef BUS_TIMEOUT_EN
  localparam logic [1:0] CauseTimeout  = 2'b11;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
`endif

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [StrbW-1:0]        wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SelW-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              err_cause_q, err_cause_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
`ifdef BUS_TIMEOUT_EN
  logic [CntW-1:0]         cnt_q, cnt_d;
`else
  // Keeps TIMEOUT_CYCLES referenced when the timeout counter is compiled out.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
  end
`endif

  logic                    hit_any;
  logic [SelW-1:0]         hit_sel;
  logic [ADDR_WIDTH-1:0]   sel_mask;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_ready;

  // Region decode of the incoming address; scanning downwards lets the lowest hit win.
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_any = 1'b1;
        hit_sel = SelW'(i);
      end
    end
  end

  assign sel_mask  = SLV_MASK[sel_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_rdata = slv_rdata_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ready = slv_ready_i[sel_q];

  // Next-state logic for the FSM and the request/response registers.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_i) begin
          addr_d  = addr_i;
          wen_d   = wen_i;
          wmask_d = wmask_i;
          wdata_d = wdata_i;
          if (!hit_any) begin
            state_d     = StErr;
            err_cause_d = CauseUnmapped;
            err_addr_d  = addr_i;
            rdata_d     = '0;
          end else if (SLV_RO[hit_sel] && !wen_i) begin
            state_d     = StErr;
            err_cause_d = CauseRoWrite;
            err_addr_d  = addr_i;
            rdata_d     = '0;
          end else begin
            state_d = StAccess;
            sel_d   = hit_sel;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StAccess: begin
        if (sel_ready) begin
          // Writes return zero data.
          rdata_d = wen_q ? sel_rdata : '0;
          state_d = StResp;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = StErr;
          err_cause_d = CauseTimeout;
          err_addr_d  = addr_q;
          rdata_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wen_q       <= 1'b1;
      wmask_q     <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      err_cause_q <= CauseNone;
      err_addr_q  <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rdata_q     <= rdata_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Chip select and slave write enable are only active during ACCESS.
  always_comb begin
    slv_csb_o = '1;
    slv_wen_o = 1'b1;
    if (state_q == StAccess) begin
      slv_csb_o[sel_q] = 1'b0;
      slv_wen_o        = wen_q;
    end
  end

  assign ack_o       = (state_q == StResp) || (state_q == StErr);
  assign err_o       = (state_q == StErr);
  assign rdata_o     = rdata_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;
  assign slv_addr_o  = addr_q & ~sel_mask;
  assign slv_wmask_o = wmask_q;
  assign slv_wdata_o = wdata_q;

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Directed bench for data_bus_interconnect with a 4-region map:
//  0: 0x0000-0x0FFF read-only, 1: 0x1E00-0x1FFF,
//  2: 0x4000-0x4FFF, 3: 0x4000-0x7FFF (overlaps 2; 2 must win).
module tb_data_bus_interconnect;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic            clk;
  logic            reset;
  logic            req;
  logic [AW-1:0]   addr;
  logic            wen;
  logic [DW/8-1:0] wmask;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            ack;
  logic            err;
  logic [1:0]      err_cause;
  logic [AW-1:0]   err_addr;
  logic [N-1:0]    csb;
  logic            swen;
  logic [AW-1:0]   saddr;
  logic [DW/8-1:0] swmask;
  logic [DW-1:0]   swdata;
  logic [N*DW-1:0] srdata;
  logic [N-1:0]    sready;

  int total = 0;
  int bad   = 0;

  data_bus_interconnect #(
    .N_SLAVES      (N),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .SLV_BASE      ({32'h0000_4000, 32'h0000_4000, 32'h0000_1E00, 32'h0000_0000}),
    .SLV_MASK      ({32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_FE00, 32'hFFFF_F000}),
    .SLV_RO        (4'b0001),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .addr_i     (addr),
    .wen_i      (wen),
    .wmask_i    (wmask),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .ack_o      (ack),
    .err_o      (err),
    .err_cause_o(err_cause),
    .err_addr_o (err_addr),
    .slv_csb_o  (csb),
    .slv_wen_o  (swen),
    .slv_addr_o (saddr),
    .slv_wmask_o(swmask),
    .slv_wdata_o(swdata),
    .slv_rdata_i(srdata),
    .slv_ready_i(sready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are checked and inputs changed on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] a, input logic w, input logic [DW/8-1:0] m,
                       input logic [DW-1:0] d);
    req   = 1'b1;
    addr  = a;
    wen   = w;
    wmask = m;
    wdata = d;
  endtask

  initial begin
    reset  = 1'b1;
    req    = 1'b0;
    addr   = '0;
    wen    = 1'b1;
    wmask  = '0;
    wdata  = '0;
    srdata = '0;
    sready = '0;
    repeat (3) cyc();

    // Reset state
    check("rst_csb", csb, 4'hF);
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_cause", err_cause, 2'b00);
    check("rst_eaddr", err_addr, 32'h0);
    check("rst_swen", swen, 1'b1);
    check("rst_saddr", saddr, 32'h0);
    check("rst_swmask", swmask, 4'h0);
    check("rst_swdata", swdata, 32'h0);
    reset = 1'b0;
    cyc();

    // Zero-wait read from region 1
    start(32'h0000_1E24, 1'b1, 4'h0, 32'h0);
    srdata[1*DW +: DW] = 32'hDEAD_BEEF;
    sready = 4'b0010;
    cyc();
    check("rd1_c1_csb", csb, 4'b1101);
    check("rd1_c1_ack", ack, 1'b0);
    check("rd1_c1_saddr", saddr, 32'h24);
    check("rd1_c1_swen", swen, 1'b1);
    cyc();
    check("rd1_c2_ack", ack, 1'b1);
    check("rd1_c2_err", err, 1'b0);
    check("rd1_c2_rdata", rdata, 32'hDEAD_BEEF);
    check("rd1_c2_csb", csb, 4'hF);
    req = 1'b0;
    sready = '0;
    cyc();
    check("rd1_c3_ack", ack, 1'b0);
    check("rd1_c3_hold", rdata, 32'hDEAD_BEEF);

    // Write to read-only region 0
    start(32'h0000_0100, 1'b0, 4'hF, 32'h0000_1234);
    cyc();
    check("ro_c1_ack", ack, 1'b1);
    check("ro_c1_err", err, 1'b1);
    check("ro_c1_csb", csb, 4'hF);
    check("ro_c1_cause", err_cause, 2'b10);
    check("ro_c1_eaddr", err_addr, 32'h0000_0100);
    check("ro_c1_rdata", rdata, 32'h0);
    req = 1'b0;
    cyc();
    check("ro_c2_ack", ack, 1'b0);
    check("ro_c2_cause", err_cause, 2'b10);

    // Unmapped access
    start(32'h8000_0000, 1'b1, 4'h0, 32'h0);
    cyc();
    check("um_c1_ack", ack, 1'b1);
    check("um_c1_err", err, 1'b1);
    check("um_c1_cause", err_cause, 2'b01);
    check("um_c1_eaddr", err_addr, 32'h8000_0000);
    req = 1'b0;
    cyc();

    // Write into overlap of regions 2/3: region 2 wins; cause stays sticky
    start(32'h0000_4008, 1'b0, 4'b0011, 32'hCAFE_F00D);
    sready = 4'b1111;
    srdata[2*DW +: DW] = 32'h7777_7777;
    cyc();
    check("ov_c1_csb", csb, 4'b1011);
    check("ov_c1_swen", swen, 1'b0);
    check("ov_c1_saddr", saddr, 32'h008);
    check("ov_c1_swdata", swdata, 32'hCAFE_F00D);
    check("ov_c1_swmask", swmask, 4'b0011);
    cyc();
    check("ov_c2_ack", ack, 1'b1);
    check("ov_c2_err", err, 1'b0);
    check("ov_c2_rdata", rdata, 32'h0);
    check("ov_c2_cause", err_cause, 2'b01);
    check("ov_c2_eaddr", err_addr, 32'h8000_0000);
    req = 1'b0;
    sready = '0;
    cyc();

    // Region 3 read with ready delayed 3 cycles; other slaves' ready ignored
    start(32'h0000_5010, 1'b1, 4'h0, 32'h0);
    srdata[3*DW +: DW] = 32'h0BAD_F00D;
    sready = 4'b0111;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check($sformatf("dl_c%0d_csb", c), csb, 4'b0111);
      check($sformatf("dl_c%0d_ack", c), ack, 1'b0);
      if (c == 4) sready = 4'b1000;
    end
    check("dl_saddr", saddr, 32'h1010);
    cyc();
    check("dl_c5_ack", ack, 1'b1);
    check("dl_c5_err", err, 1'b0);
    check("dl_c5_rdata", rdata, 32'h0BAD_F00D);
    req = 1'b0;
    sready = '0;
    cyc();

    // Slave that never answers
    start(32'h0000_1E04, 1'b1, 4'h0, 32'h0);
`ifdef BUS_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check($sformatf("to_c%0d_csb", c), csb, 4'b1101);
      check($sformatf("to_c%0d_ack", c), ack, 1'b0);
    end
    cyc();
    check("to_c5_ack", ack, 1'b1);
    check("to_c5_err", err, 1'b1);
    check("to_c5_cause", err_cause, 2'b11);
    check("to_c5_eaddr", err_addr, 32'h0000_1E04);
    check("to_c5_csb", csb, 4'hF);
    check("to_c5_rdata", rdata, 32'h0);
`else
    srdata[1*DW +: DW] = 32'h5A5A_5A5A;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check($sformatf("wt_c%0d_csb", c), csb, 4'b1101);
      check($sformatf("wt_c%0d_ack", c), ack, 1'b0);
      if (c == 8) sready = 4'b0010;
    end
    cyc();
    check("wt_c9_ack", ack, 1'b1);
    check("wt_c9_err", err, 1'b0);
    check("wt_c9_rdata", rdata, 32'h5A5A_5A5A);
    check("wt_c9_cause", err_cause, 2'b01);
`endif
    req = 1'b0;
    sready = '0;
    cyc();

    // Back-to-back: req left high across the ack starts a second access
    start(32'h0000_1E00, 1'b1, 4'h0, 32'h0);
    srdata[1*DW +: DW] = 32'h1111_1111;
    sready = 4'b0010;
    cyc();
    check("bb_c1_csb", csb, 4'b1101);
    cyc();
    check("bb_c2_rdata", rdata, 32'h1111_1111);
    check("bb_c2_ack", ack, 1'b1);
    srdata[1*DW +: DW] = 32'h2222_2222;
    cyc();
    check("bb_c3_csb", csb, 4'hF);
    check("bb_c3_ack", ack, 1'b0);
    cyc();
    check("bb_c4_csb", csb, 4'b1101);
    cyc();
    check("bb_c5_ack", ack, 1'b1);
    check("bb_c5_rdata", rdata, 32'h2222_2222);
    req = 1'b0;
    sready = '0;
    cyc();
    check("bb_c6_ack", ack, 1'b0);

    // Reset pulsed during ACCESS abandons the access
    start(32'h0000_1E08, 1'b1, 4'h0, 32'h0);
    cyc();
    check("rs_c1_csb", csb, 4'b1101);
    reset = 1'b1;
    cyc();
    check("rs_c2_csb", csb, 4'hF);
    check("rs_c2_ack", ack, 1'b0);
    check("rs_c2_rdata", rdata, 32'h0);
    check("rs_c2_cause", err_cause, 2'b00);
    check("rs_c2_eaddr", err_addr, 32'h0);
    reset = 1'b0;
    req = 1'b0;
    sready = 4'b0010;
    cyc();
    check("rs_c3_ack", ack, 1'b0);
    check("rs_c3_csb", csb, 4'hF);
    cyc();
    check("rs_c4_ack", ack, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
